// File: rtl/alu_exec_stage.sv
// alu_exec_stage -- single-issue, multi-cycle 2-bit ALU execution stage.
//
// Three-state FSM (IDLE -> EXEC -> DONE -> IDLE). An operation is captured
// when op_valid && op_ready. It then waits LATENCY-1 extra cycles in EXEC and
// loads the result registers on the edge that enters DONE. DONE asserts
// res_valid for exactly one cycle.
//
// Parameters
//   LATENCY   EXEC cycles per operation, legal range 1..4
// Ports
//   clk, rst             clock, synchronous active-high reset
//   op_valid / op_ready  operation handshake; ready only in IDLE
//   opcode, in_A, in_B   operation select and 2-bit unsigned operands
//   res, status          registered result and carry/borrow/compare flag
//   zero, illegal        registered flags: res==0, undefined opcode
//   res_valid            one-cycle completion pulse
//   op_count             completed-operation counter, wraps at 256
module alu_exec_stage #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [4:0] opcode,
  input  logic [1:0] in_A,
  input  logic [1:0] in_B,
  output logic [1:0] res,
  output logic       status,
  output logic       zero,
  output logic       illegal,
  output logic       res_valid,
  output logic [7:0] op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Wait-counter load value; LATENCY is at most 4, so 2 bits suffice.
  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  typedef struct packed {
    logic [4:0] opc;
    logic [1:0] a;
    logic [1:0] b;
  } op_req_t;

  typedef struct packed {
    logic [1:0] res;
    logic       status;
    logic       zero;
    logic       illegal;
  } op_rsp_t;

  logic [1:0] state;
  logic [1:0] wait_cnt;
  op_req_t    req_q;
  op_rsp_t    rsp_d;
  logic [2:0] sum3;

  assign op_ready  = (state == S_IDLE);
  assign res_valid = (state == S_DONE);

  // Combinational ALU evaluated on the captured operation only, so input
  // changes after acceptance cannot leak into the result.
  assign sum3 = {1'b0, req_q.a} + {1'b0, req_q.b};

  always_comb begin
    rsp_d = '0;
    case (req_q.opc)
      5'd0: begin rsp_d.res = sum3[1:0];            rsp_d.status = sum3[2];              end
      5'd1: begin rsp_d.res = req_q.a - req_q.b;    rsp_d.status = (req_q.a < req_q.b);  end
      5'd2: begin rsp_d.res = req_q.a & req_q.b;                                          end
      5'd3: begin rsp_d.res = req_q.a | req_q.b;                                          end
      5'd4: begin rsp_d.res = req_q.a ^ req_q.b;                                          end
      5'd5: begin rsp_d.res = req_q.a + 2'd1;       rsp_d.status = (req_q.a == 2'd3);    end
      5'd6: begin rsp_d.res = req_q.a - 2'd1;       rsp_d.status = (req_q.a == 2'd0);    end
      5'd7: begin rsp_d.res = req_q.a;              rsp_d.status = (req_q.a > req_q.b);  end
      default: rsp_d.illegal = 1'b1;  // res=0, status=0
    endcase
    rsp_d.zero = (rsp_d.res == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      req_q    <= '0;
      res      <= '0;
      status   <= 1'b0;
      zero     <= 1'b1;
      illegal  <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            req_q    <= '{opc: opcode, a: in_A, b: in_B};
            wait_cnt <= CNT_INIT;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else begin
            res      <= rsp_d.res;
            status   <= rsp_d.status;
            zero     <= rsp_d.zero;
            illegal  <= rsp_d.illegal;
            // Counted on DONE entry so op_count is already current while
            // res_valid is high; a reset in DONE clears it anyway.
            op_count <= op_count + 8'd1;
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid1, op_valid3;
  logic [4:0] opcode;
  logic [1:0] in_A, in_B;

  logic       op_ready1, status1, zero1, illegal1, res_valid1;
  logic [1:0] res1;
  logic [7:0] op_count1;
  logic       op_ready3, status3, zero3, illegal3, res_valid3;
  logic [1:0] res3;
  logic [7:0] op_count3;

  int total = 0;
  int bad   = 0;
  logic [7:0] ecnt1;

  always #5 clk = ~clk;

  alu_exec_stage #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .op_valid(op_valid1), .op_ready(op_ready1),
    .opcode(opcode), .in_A(in_A), .in_B(in_B), .res(res1), .status(status1),
    .zero(zero1), .illegal(illegal1), .res_valid(res_valid1), .op_count(op_count1)
  );

  alu_exec_stage #(.LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .op_valid(op_valid3), .op_ready(op_ready3),
    .opcode(opcode), .in_A(in_A), .in_B(in_B), .res(res3), .status(status3),
    .zero(zero3), .illegal(illegal3), .res_valid(res_valid3), .op_count(op_count3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One LATENCY=1 operation on u1: accept, complete, return to IDLE.
  task automatic run1(input string tag, input logic [4:0] opc, input logic [1:0] a,
                      input logic [1:0] b, input logic [1:0] eres, input logic est,
                      input logic eill, input bit full);
    op_valid1 = 1'b1; opcode = opc; in_A = a; in_B = b;
    tick();                                    // edge k: accept
    op_valid1 = 1'b0;
    ecnt1 = ecnt1 + 8'd1;
    if (full) begin
      chk({tag, ".rdy_exec"}, op_ready1, 0);
      chk({tag, ".vld_exec"}, res_valid1, 0);
    end
    tick();                                    // edge k+1: enter DONE
    chk({tag, ".vld"}, res_valid1, 1);
    chk({tag, ".res"}, res1, eres);
    chk({tag, ".cnt"}, op_count1, ecnt1);
    if (full) begin
      chk({tag, ".st"},   status1, est);
      chk({tag, ".zero"}, zero1, (eres == 2'd0));
      chk({tag, ".ill"},  illegal1, eill);
    end
    tick();                                    // edge k+2: back to IDLE
    if (full) begin
      chk({tag, ".vld_off"}, res_valid1, 0);
      chk({tag, ".rdy"},     op_ready1, 1);
      chk({tag, ".hold"},    res1, eres);
    end
  endtask

  initial begin
    rst = 1'b1; op_valid1 = 1'b0; op_valid3 = 1'b0;
    opcode = '0; in_A = '0; in_B = '0; ecnt1 = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst.rdy",  op_ready1, 1);
    chk("rst.res",  res1, 0);
    chk("rst.st",   status1, 0);
    chk("rst.zero", zero1, 1);
    chk("rst.ill",  illegal1, 0);
    chk("rst.vld",  res_valid1, 0);
    chk("rst.cnt",  op_count1, 0);
    chk("rst3.rdy", op_ready3, 1);
    chk("rst3.zero", zero3, 1);

    // Directed ALU vectors, back to back on u1
    run1("add32",  5'd0, 2'd3, 2'd2, 2'd1, 1'b1, 1'b0, 1);
    run1("add11",  5'd0, 2'd1, 2'd1, 2'd2, 1'b0, 1'b0, 1);
    run1("sub12",  5'd1, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 1);
    run1("sub22",  5'd1, 2'd2, 2'd2, 2'd0, 1'b0, 1'b0, 1);
    run1("and31",  5'd2, 2'd3, 2'd1, 2'd1, 1'b0, 1'b0, 1);
    run1("or12",   5'd3, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0, 1);
    run1("xor33",  5'd4, 2'd3, 2'd3, 2'd0, 1'b0, 1'b0, 1);
    run1("inc3",   5'd5, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1);
    run1("dec0",   5'd6, 2'd0, 2'd0, 2'd3, 1'b1, 1'b0, 1);
    run1("dec2",   5'd6, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1);
    run1("ill9",   5'd9, 2'd3, 2'd3, 2'd0, 1'b0, 1'b1, 1);
    run1("cmp31",  5'd7, 2'd3, 2'd1, 2'd3, 1'b1, 1'b0, 1);
    run1("cmp13",  5'd7, 2'd1, 2'd3, 2'd1, 1'b0, 1'b0, 1);
    run1("ill31",  5'd31, 2'd1, 2'd1, 2'd0, 1'b0, 1'b1, 1);

    // LATENCY=3: operand change after acceptance, op_valid held during EXEC
    op_valid3 = 1'b1; opcode = 5'd2; in_A = 2'd2; in_B = 2'd2;
    tick();                                    // edge 0: accept
    in_A = 2'd0;
    tick();                                    // edge 1
    chk("l3.vld_e1", res_valid3, 0);
    chk("l3.rdy_e1", op_ready3, 0);
    tick();                                    // edge 2
    chk("l3.vld_e2", res_valid3, 0);
    tick();                                    // edge 3
    chk("l3.vld", res_valid3, 1);
    chk("l3.res", res3, 2);
    chk("l3.cnt", op_count3, 1);
    op_valid3 = 1'b0;
    tick();                                    // edge 4
    chk("l3.rdy", op_ready3, 1);
    chk("l3.vld_off", res_valid3, 0);
    repeat (6) tick();
    chk("l3.noqueue_cnt", op_count3, 1);
    chk("l3.noqueue_rdy", op_ready3, 1);

    // Reset during EXEC abandons the operation
    op_valid3 = 1'b1; opcode = 5'd0; in_A = 2'd1; in_B = 2'd1;
    tick();                                    // accept
    op_valid3 = 1'b0;
    rst = 1'b1;
    tick();                                    // reset edge while in EXEC
    rst = 1'b0; ecnt1 = '0;
    chk("rexec.rdy", op_ready3, 1);
    chk("rexec.cnt", op_count3, 0);
    chk("rexec.vld", res_valid3, 0);
    repeat (4) begin
      tick();
      chk("rexec.nopulse", res_valid3, 0);
    end
    chk("rexec.cnt_after", op_count3, 0);

    // No acceptance on a reset edge
    op_valid3 = 1'b1; op_valid1 = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; op_valid3 = 1'b0; op_valid1 = 1'b0;
    tick();
    chk("rstacc.rdy3", op_ready3, 1);
    chk("rstacc.rdy1", op_ready1, 1);

    // 256 INC operations: op_count wraps to 0
    for (int i = 0; i < 255; i++)
      run1("incloop", 5'd5, 2'(i), 2'd0, 2'(i + 1), 1'b0, 1'b0, 0);
    chk("wrap.cnt255", op_count1, 255);
    run1("incwrap", 5'd5, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1);
    chk("wrap.cnt0", op_count1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
